mix_columns_iter: RTL and testbench
===================================

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: AES state columns transformed per clock; legal values 1, 2, 4.
REQ-002 Parameter DEC_EN, default 1: 1 enables runtime InvMixColumns; 0 builds forward-only, and mode_i is ignored.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_data/mode_i are valid.
REQ-006 in_ready  output  1  block can accept a new state.
REQ-007 in_data  input  128  state; column c = bits [127-32c -: 32]; byte 0 of each column in the column's MSB.
REQ-008 mode_i  input  1  0 = MixColumns (02 03 01 01 circulant), 1 = InvMixColumns (0e 0b 0d 09 circulant).
REQ-009 out_valid  output  1  out_data holds a completed result.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  128  transformed state, same column/byte layout as in_data.
REQ-012 busy  output  1  high in BUSY state.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-014 Input handshake SHALL complete on a rising edge with in_valid & in_ready; in_data and mode_i are captured into an internal state register and mode register.
REQ-015 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; it SHALL be 0 in BUSY.
REQ-016 On acceptance the FSM SHALL enter BUSY with the column counter at 0.
REQ-017 Each BUSY cycle SHALL replace COLS_PER_CYCLE columns, starting at counter value col, with their transform, and advance col by COLS_PER_CYCLE.
REQ-018 The counter SHALL be 2 bits wide with modulo-4 wrap.
REQ-019 When the final column group is written, the FSM SHALL move to DONE.
REQ-020 out_valid SHALL rise exactly 4/COLS_PER_CYCLE cycles after the accepting edge.
REQ-021 Sustained throughput SHALL be one block per 4/COLS_PER_CYCLE + 1 cycles.
REQ-022 In DONE, out_valid=1 and out_data SHALL be the full result, held stable while out_ready=0.
REQ-023 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-024 DONE with out_ready=1 and in_valid=1 SHALL accept the new block on the same edge and go to BUSY.
REQ-025 GF(2^8) multiplication SHALL use xtime with polynomial 0x11B.
REQ-026 Each output byte is the XOR of the four byte products.
REQ-027 Coefficient 09 = x8+x1, 0b = x8+x2+x1, 0d = x8+x4+x1, 0e = x8+x4+x2.
REQ-028 Output row r SHALL use the coefficient row rotated right by r.
REQ-029 mode_i SHALL be sampled only at acceptance; changes during BUSY or DONE have no effect.
REQ-030 With DEC_EN=0, the mode register SHALL be tied to 0.
REQ-031 out_data in IDLE and BUSY is don't-care to consumers, but SHALL never contain X after the first reset.
REQ-032 COLS_PER_CYCLE outside {1,2,4} SHALL cause an elaboration-time error.
REQ-033 The block SHALL have no combinational path from in_valid to out_valid.
REQ-034 The only combinational input-to-output path SHALL be out_ready to in_ready.

Reset
REQ-035 On a rising edge with rst_n=0, FSM=IDLE, counter=0, mode register=0, and the state register=0.
REQ-036 After that reset, out_valid=0, busy=0, in_ready=1, and out_data=0.
REQ-037 Reset asserted in BUSY or DONE SHALL discard the block in flight; no out_valid pulse follows.
REQ-038 In-flight inputs SHALL be ignored during reset; in_valid is not accepted while rst_n=0.

Verification
REQ-039 Forward mode, COLS_PER_CYCLE=1, each column db135345 -> out_data = 4x 8e4da1bc; out_valid rises 4 cycles after acceptance.
REQ-040 Inverse mode, columns 8e4da1bc, 9fdc589d, 01010101, 4d7ebdf8 -> db135345, f20a225c, 01010101, 2d26314c.
REQ-041 Parameter sweep COLS_PER_CYCLE=1/2/4, columns d4d4d4d5, c6c6c6c6, 2d26314c, f20a225c forward -> d5d5d7d6, c6c6c6c6, 4d7ebdf8, 9fdc589d; latency 4/2/1.
REQ-042 Back-pressure: hold out_ready=0 for 10 cycles, toggling in_valid, in_data and mode_i -> out_data stable, in_ready=0, no capture; releasing with in_valid=1 gives back-to-back acceptance at the release edge.
REQ-043 rst_n=0 pulsed for one edge mid-BUSY -> next cycle IDLE, in_ready=1, out_data=0; no out_valid for the aborted block.
REQ-044 Round trip: random state forward then inverse, 1000 blocks, random valid/ready -> output equals original; reference-model compare on every block.

Source files
------------

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Result valid 4/COLS_PER_CYCLE cycles after acceptance; held in DONE until out_ready.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit DEC_EN         = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         mode_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic         mode_q, mode_d;
  logic [127:0] data_q, data_d;
  logic [2:0]   col_sum;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients built from x1/x2/x4/x8 partial products; row r is the coefficient row rotated right by r.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xtime(a[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      if (inv)
        res[31-8*r -: 8] = (m8[r] ^ m4[r] ^ m2[r])
                         ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
                         ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
                         ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
      else
        res[31-8*r -: 8] = m2[r]
                         ^ (m2[(r+1)%4] ^ a[(r+1)%4])
                         ^ a[(r+2)%4]
                         ^ a[(r+3)%4];
    end
    return res;
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = data_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    mode_d  = mode_q;
    data_d  = data_q;
    // Carry out of the 2-bit counter marks the last column group.
    col_sum = {1'b0, col_q} + 3'(COLS_PER_CYCLE);
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (in_valid && in_ready) begin
          state_d = BUSY;
          col_d   = 2'd0;
          data_d  = in_data;
          mode_d  = DEC_EN && mode_i;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          int idx;
          idx = int'(col_q + 2'(g));
          data_d[127-32*idx -: 32] = mix_col(data_q[127-32*idx -: 32], mode_q);
        end
        col_d = col_sum[1:0];
        if (col_sum[2]) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2, 4 side by side.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         mode_i    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] in_data   [3];
  logic [127:0] out_data  [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(1 << k), .DEC_EN(1'b1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .mode_i    (mode_i[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k]),
      .busy      (busy[k])
    );
  end

  logic [127:0] exp_mem [3][64];
  int           wp [3] = '{default: 0};
  int           rp [3] = '{default: 0};
  bit           awaiting [3];
  int           acc_cyc  [3];
  bit           hold_vld [3];
  logic [127:0] hold_dat [3];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  int           done_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: shift-and-add GF(2^8) multiply and a plain circulant matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - row + 4) % 4], a[j]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 90000) begin
      $display("FAIL global_timeout cycles=%0d limit=90000", cyc);
      $fatal(1, "global timeout");
    end
  end

  // Monitor: pops on output handshake, tracks first-valid latency and hold stability.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        awaiting[k] = 1'b0;
        hold_vld[k] = 1'b0;
      end else begin
        if (out_valid[k]) begin
          if (hold_vld[k]) chk($sformatf("hold_stable_%0d", k), out_data[k], hold_dat[k]);
          if (awaiting[k]) begin
            chk_int($sformatf("latency_%0d", k), cyc - acc_cyc[k], 4 >> k);
            awaiting[k] = 1'b0;
          end
          if (out_ready[k]) begin
            hold_vld[k] = 1'b0;
            if (rp[k] == wp[k]) begin
              checks++;
              failures++;
              $display("FAIL spurious_out_%0d actual=out_valid required=no_output data=%h", k, out_data[k]);
            end else begin
              chk($sformatf("data_%0d_blk%0d", k, rp[k]), out_data[k], exp_mem[k][rp[k] % 64]);
              rp[k]++;
            end
          end else begin
            hold_vld[k] = 1'b1;
            hold_dat[k] = out_data[k];
          end
        end else begin
          hold_vld[k] = 1'b0;
        end
        if (in_valid[k] && in_ready[k]) begin
          awaiting[k] = 1'b1;
          acc_cyc[k]  = cyc + 1;
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic [127:0] e);
    exp_mem[k][wp[k] % 64] = e;
    wp[k]++;
  endtask

  task automatic send(input int k, input logic [127:0] d, input logic m, input bit push,
                      input logic [127:0] e);
    int n = 0;
    if (push) push_exp(k, e);
    in_data[k]  = d;
    mode_i[k]   = m;
    in_valid[k] = 1'b1;
    @(negedge clk);
    while (!in_ready[k] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout_%0d actual=no_in_ready required=accept", k);
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_data[k]  = rand128();
    mode_i[k]   = 1'($urandom_range(0, 1));
  endtask

  function automatic bit pending();
    return (rp[0] != wp[0]) || (rp[1] != wp[1]) || (rp[2] != wp[2]);
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (pending() && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (pending()) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=outputs_pending required=drained");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_traffic(input int k, input int pairs);
    logic [127:0] x;
    logic [127:0] y;
    for (int p = 0; p < pairs; p++) begin
      x = rand128();
      y = ref_mix(x, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(k, x, 1'b0, 1'b1, y);
      send(k, y, 1'b1, 1'b1, x);
    end
    done_cnt++;
  endtask

  initial begin
    logic [127:0] r;
    logic         m;
    int           n;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b1;
      in_data[k]   = rand128();
      mode_i[k]    = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_bit($sformatf("rst_out_valid_%0d", k), out_valid[k], 1'b0);
      chk_bit($sformatf("rst_busy_%0d", k), busy[k], 1'b0);
      chk_bit($sformatf("rst_in_ready_%0d", k), in_ready[k], 1'b1);
      chk($sformatf("rst_out_data_%0d", k), out_data[k], 128'h0);
    end
    @(posedge clk);
    #1;

    send(0, {4{32'hdb135345}}, 1'b0, 1'b1, {4{32'h8e4da1bc}});
    send(0, {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8}, 1'b1, 1'b1,
         {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c});
    for (int k = 0; k < 3; k++)
      send(k, {32'hd4d4d4d5, 32'hc6c6c6c6, 32'h2d26314c, 32'hf20a225c}, 1'b0, 1'b1,
           {32'hd5d5d7d6, 32'hc6c6c6c6, 32'h4d7ebdf8, 32'h9fdc589d});
    wait_drain();

    // Back-pressure: result must hold and no capture while out_ready is low.
    out_ready[0] = 1'b0;
    r = rand128();
    m = 1'($urandom_range(0, 1));
    send(0, r, m, 1'b1, ref_mix(r, m));
    n = 0;
    while (!out_valid[0] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk_bit("bp_out_valid", out_valid[0], 1'b1);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid[0] = 1'($urandom_range(0, 1));
      in_data[0]  = rand128();
      mode_i[0]   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_bit("bp_in_ready", in_ready[0], 1'b0);
    end
    @(posedge clk);
    #1;
    r = rand128();
    push_exp(0, ref_mix(r, 1'b0));
    in_data[0]   = r;
    mode_i[0]    = 1'b0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk_bit("release_in_ready", in_ready[0], 1'b1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_drain();

    // Reset pulse mid-BUSY: block discarded, no output may follow.
    send(0, rand128(), 1'b0, 1'b0, 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("abort_in_ready", in_ready[0], 1'b1);
    chk_bit("abort_busy", busy[0], 1'b0);
    chk_bit("abort_out_valid", out_valid[0], 1'b0);
    chk("abort_out_data", out_data[0], 128'h0);
    repeat (8) @(posedge clk);
    #1;

    // Round trip with random valid/ready on all three widths.
    done_cnt = 0;
    fork
      rand_traffic(0, 500);
      rand_traffic(1, 500);
      rand_traffic(2, 500);
      begin
        while (done_cnt < 3) begin
          @(posedge clk);
          #1;
          for (int k = 0; k < 3; k++) out_ready[k] = 1'($urandom_range(0, 1));
        end
      end
    join
    for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
    wait_drain();
    chk_int("blocks_seen_0", rp[0], wp[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
